// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the alu_arbiter block: FSM state encoding,
// ALU opcode values and flag bit positions.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int unsigned FLAG_ZERO  = 32'd3;
  localparam int unsigned FLAG_NEG   = 32'd2;
  localparam int unsigned FLAG_CARRY = 32'd1;
  localparam int unsigned FLAG_OVF   = 32'd0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side signal bundle for alu_arbiter; slave is the arbiter's
// view, master is the view of the blocks around it.
interface alu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_opcode;

  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            rsp_flags;
  logic                  rsp_error;

  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [3:0]            alu_opcode;
  logic                  alu_execute;
  logic [WIDTH-1:0]      alu_result;
  logic [3:0]            alu_flags;
  logic                  alu_done;

  modport slave (
    input  req_valid, req_a, req_b, req_opcode,
    input  alu_result, alu_flags, alu_done,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error,
    output alu_a, alu_b, alu_opcode, alu_execute
  );

  modport master (
    output req_valid, req_a, req_b, req_opcode,
    output alu_result, alu_flags, alu_done,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error,
    input  alu_a, alu_b, alu_opcode, alu_execute
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the previous
// winner and wraps modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    logic             found;
    logic             hit;
    logic [IDX_W-1:0] cand;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    hit         = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand          = IDX_W'((int'(last_grant_i) + k) % NREQ);
      hit           = ~found & req_i[cand];
      grant_o[cand] = grant_o[cand] | hit;
      grant_idx_o   = hit ? cand : grant_idx_o;
      found         = found | hit;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, issue, wait for the
// done rising edge, respond. Optional WAIT watchdog under ALU_ARB_TIMEOUT_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] grant_idx_s;
  logic [NREQ-1:0]  grant_oh_s;
  logic             any_req_s;
  logic             accept_s;
  logic             done_q;
  logic             done_evt_s;
  logic             tmo_hit_s;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_opcode_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [NREQ-1:0]  req_ready_s;
  logic [NREQ-1:0]  rsp_valid_s;
  logic             alu_execute_s;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_oh_s),
    .grant_idx_o  (grant_idx_s),
    .any_o        (any_req_s)
  );

  assign accept_s   = (state_q == ST_IDLE) & any_req_s;
  // A done level that was already high when WAIT began is not an event.
  assign done_evt_s = bus.alu_done & ~done_q;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             rsp_error_q;

  assign tmo_hit_s = (state_q == ST_WAIT) & (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, cleared while issuing so it starts at zero in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      tmo_q <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Error marker travels with the captured response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_error_q <= 1'b0;
    end else if ((state_q == ST_WAIT) && done_evt_s) begin
      rsp_error_q <= 1'b0;
    end else if (tmo_hit_s) begin
      rsp_error_q <= 1'b1;
    end
  end

  assign bus.rsp_error = rsp_error_q;
`else
  assign tmo_hit_s     = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) state_d = ST_ISSUE;
        else           state_d = ST_IDLE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_evt_s | tmo_hit_s) state_d = ST_RESP;
        else                        state_d = ST_WAIT;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register.
  always_comb begin
    req_ready_s   = '0;
    rsp_valid_s   = '0;
    alu_execute_s = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready_s   = grant_oh_s;
      ST_ISSUE: alu_execute_s = 1'b1;
      ST_WAIT:  alu_execute_s = 1'b0;
      ST_RESP:  rsp_valid_s   = NREQ'(1'b1) << last_grant_q;
      default:  alu_execute_s = 1'b0;
    endcase
  end

  // Operand capture on acceptance and response capture on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      last_grant_q <= IDX_W'(NREQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      done_q <= bus.alu_done;
      if (accept_s) begin
        last_grant_q <= grant_idx_s;
        alu_a_q      <= bus.req_a[grant_idx_s*WIDTH +: WIDTH];
        alu_b_q      <= bus.req_b[grant_idx_s*WIDTH +: WIDTH];
        alu_opcode_q <= bus.req_opcode[grant_idx_s*4 +: 4];
      end
      if ((state_q == ST_WAIT) && done_evt_s) begin
        rsp_result_q <= bus.alu_result;
        rsp_flags_q  <= bus.alu_flags;
      end else if (tmo_hit_s) begin
        rsp_result_q <= '0;
        rsp_flags_q  <= '0;
      end
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.rsp_valid   = rsp_valid_s;
  assign bus.alu_execute = alu_execute_s;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_flags   = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU, a transaction-level
// model checked every cycle, and directed scenarios pinned by literal values.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int QD  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  alu_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {flags Z,N,C,V, result}.
  function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] m;
    logic [7:0]  r;
    logic        c;
    logic        v;
    c = 1'b0; v = 1'b0; r = 8'h00;
    w = 9'h000; m = 16'h0000;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd8: begin w = {1'b0, a} - {1'b0, b}; r = a; c = w[8]; end
      4'd9: begin m = {8'h00, a} * {8'h00, b}; r = m[7:0]; c = |m[15:8]; end
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), r[7], c, v, r};
  endfunction

  // Per-requester request queues; acc_cnt doubles as the queue head.
  logic [3:0] q_op [N][QD];
  logic [7:0] q_a  [N][QD];
  logic [7:0] q_b  [N][QD];
  int         tail    [N];
  int         acc_cnt [N];

  task automatic push(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    q_op[r][tail[r]] = op;
    q_a[r][tail[r]]  = a;
    q_b[r][tail[r]]  = b;
    tail[r]++;
  endtask

  // Model state.
  bit         m_busy, m_pend, acc_prev;
  int         m_owner, m_acc, m_rsp_cyc, m_last, cyc, n_acc;
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_op, m_flg;
  logic       m_err, prev_done;
  bit         alu_auto;
  int         log_idx [64];
  logic [7:0] log_res [64];
  logic [3:0] log_flg [64];
  logic       log_err [64];
  int         n_log;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Requester driver: present the head of each queue until it is accepted.
  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_opcode = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = (acc_cnt[i] < tail[i]);
        if (acc_cnt[i] < tail[i]) begin
          bus.req_a[i*W +: W]      = q_a[i][acc_cnt[i]];
          bus.req_b[i*W +: W]      = q_b[i][acc_cnt[i]];
          bus.req_opcode[i*4 +: 4] = q_op[i][acc_cnt[i]];
        end
      end
    end
  end

  // Behavioural ALU: after execute, raise done for one cycle after 1..3 cycles.
  initial begin
    int lat;
    lat = 1;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    bus.alu_flags  = '0;
    forever begin
      @(posedge clk); #1;
      if (alu_auto && rst_n && bus.alu_execute) begin
        repeat (lat) @(posedge clk);
        #1;
        {bus.alu_flags, bus.alu_result} = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);
        bus.alu_done = 1'b1;
        @(posedge clk); #1;
        bus.alu_done = 1'b0;
        lat = (lat % 3) + 1;
      end
    end
  end

  // Compare process: checks every DUT output against the model each cycle.
  initial begin
    logic [N-1:0] exp_ready, exp_rsp;
    int g, idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.alu_execute, bus.rsp_error,
                              bus.rsp_result, bus.rsp_flags, bus.alu_a, bus.alu_b, bus.alu_opcode}, 64'd0);
        m_busy = 1'b0; m_pend = 1'b0; acc_prev = 1'b0; m_last = N - 1;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = '0; m_err = 1'b0;
        prev_done = 1'b0;
      end else begin
        g         = m_busy ? -1 : rr_pick(bus.req_valid, m_last);
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        exp_rsp   = (m_pend && cyc == m_rsp_cyc) ? (N'(1) << m_owner) : '0;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("alu_execute", bus.alu_execute, acc_prev);
        chk("rsp_valid", bus.rsp_valid, exp_rsp);
        chk("rsp_data", {bus.rsp_error, bus.rsp_result, bus.rsp_flags}, {m_err, m_res, m_flg});
        chk("alu_operands", {bus.alu_a, bus.alu_b, bus.alu_opcode}, {m_a, m_b, m_op});
        if (bus.rsp_valid != '0 && n_log < 64) begin
          idx = -1;
          for (int i = N - 1; i >= 0; i--) if (bus.rsp_valid[i]) idx = i;
          log_idx[n_log] = idx;
          log_res[n_log] = bus.rsp_result;
          log_flg[n_log] = bus.rsp_flags;
          log_err[n_log] = bus.rsp_error;
          n_log++;
        end
        if (exp_rsp != '0) begin
          m_busy = 1'b0;
          m_pend = 1'b0;
        end
        acc_prev = 1'b0;
        if (g >= 0) begin
          m_busy   = 1'b1; m_owner = g; m_acc = cyc; m_last = g; acc_prev = 1'b1;
          m_a      = bus.req_a[g*W +: W];
          m_b      = bus.req_b[g*W +: W];
          m_op     = bus.req_opcode[g*4 +: 4];
          acc_cnt[g]++;
          n_acc++;
        end
        if (m_busy && !m_pend && cyc >= m_acc + 2) begin
          if (bus.alu_done && !prev_done) begin
            m_pend = 1'b1; m_rsp_cyc = cyc + 1;
            m_res = bus.alu_result; m_flg = bus.alu_flags; m_err = 1'b0;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (cyc == m_acc + 2 + TMO - 1) begin
            m_pend = 1'b1; m_rsp_cyc = cyc + 1;
            m_res = '0; m_flg = '0; m_err = 1'b1;
          end
`endif
        end
        prev_done = bus.alu_done;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (acc_cnt[i] < tail[i]) return 1'b0;
    return !m_busy && (bus.req_valid == '0);
  endfunction

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (drained()) break;
      step();
    end
    chk({name, "_drain"}, drained(), 1'b1);
  endtask

  task automatic wait_acc(input string name, input int n0);
    for (int i = 0; i < 50; i++) begin
      if (n_acc > n0) break;
      step();
    end
    chk({name, "_accept"}, (n_acc > n0), 1'b1);
  endtask

  initial begin
    int base, n0;
    alu_auto = 1'b1;
    n_log    = 0;
    for (int i = 0; i < 64; i++) log_idx[i] = -1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Contention: two rounds, both starting at requester 0.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, OP_ADD, 8'(i + 1), 8'h00);
    wait_idle("contention");
    chk("contention_count", n_log, 8);
    for (int k = 0; k < 8; k++) begin
      chk("contention_order", log_idx[k], k % 4);
      chk("contention_result", log_res[k], 8'(k % 4 + 1));
    end

    // Single ADD 05+03.
    base = n_log;
    push(0, OP_ADD, 8'h05, 8'h03);
    wait_idle("single");
    chk("single_idx", log_idx[base], 0);
    chk("single_result", log_res[base], 8'h08);
    chk("single_flags", log_flg[base], 4'b0000);
    chk("single_error", log_err[base], 1'b0);

    // Fairness: requester 1 continuous, requester 2 once.
    base = n_log;
    n0   = n_acc;
    for (int k = 1; k <= 3; k++) push(1, OP_ADD, 8'h10, 8'(k));
    wait_acc("fair", n0);
    push(2, OP_AND, 8'hFF, 8'h3C);
    wait_idle("fair");
    chk("fair_order0", log_idx[base], 1);
    chk("fair_order1", log_idx[base + 1], 2);
    chk("fair_order2", log_idx[base + 2], 1);
    chk("fair_order3", log_idx[base + 3], 1);
    chk("fair_r2_result", log_res[base + 1], 8'h3C);
    chk("fair_r1_result", log_res[base + 2], 8'h12);

    // Stuck done: high before issue, only a fresh rising edge completes.
    alu_auto     = 1'b0;
    bus.alu_done = 1'b1;
    base = n_log;
    n0   = n_acc;
    push(3, OP_XOR, 8'hA5, 8'h0F);
    repeat (8) step();
    chk("stuck_accepted", n_acc, n0 + 1);
    chk("stuck_no_rsp", n_log, base);
    bus.alu_done = 1'b0;
    step();
    bus.alu_result = 8'hAA;
    bus.alu_flags  = 4'b0100;
    bus.alu_done   = 1'b1;
    step();
    bus.alu_done = 1'b0;
    wait_idle("stuck");
    chk("stuck_idx", log_idx[base], 3);
    chk("stuck_result", log_res[base], 8'hAA);
    chk("stuck_flags", log_flg[base], 4'b0100);

`ifdef ALU_ARB_TIMEOUT_EN
    // Timeout: done never rises.
    base = n_log;
    push(0, OP_ADD, 8'h01, 8'h01);
    wait_idle("timeout");
    chk("timeout_error", log_err[base], 1'b1);
    chk("timeout_result", log_res[base], 8'h00);
    chk("timeout_flags", log_flg[base], 4'b0000);
    alu_auto = 1'b1;
    push(0, OP_SUB, 8'h08, 8'h03);
    wait_idle("after_timeout");
    chk("after_timeout_result", log_res[base + 1], 8'h05);
    chk("after_timeout_error", log_err[base + 1], 1'b0);
    alu_auto = 1'b0;
`endif

    // Reset during WAIT: no response, then MUL from requester 2.
    base = n_log;
    n0   = n_acc;
    push(1, OP_ADD, 8'h02, 8'h02);
    wait_acc("reset", n0);
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async", {bus.req_ready, bus.rsp_valid, bus.alu_execute, bus.rsp_error,
                        bus.rsp_result, bus.rsp_flags, bus.alu_a, bus.alu_b, bus.alu_opcode}, 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("reset_no_rsp", n_log, base);
    alu_auto = 1'b1;
    push(2, OP_MUL, 8'h04, 8'h05);
    wait_idle("mul");
    chk("mul_idx", log_idx[base], 2);
    chk("mul_result", log_res[base], 8'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one `simple_alu` instance between `NREQ` independent requesters. Each requester hands over an operand pair and opcode on a valid/ready handshake. The arbiter registers the winning request, pulses the ALU's `execute`, and waits for the ALU's `done`. It then returns `result`/`flags` to that requester with a one-cycle response strobe. It sits between the ALU and the client blocks that need occasional arithmetic.

## Interface
- `WIDTH`, 8, operand/result width; must match the ALU.
- `NREQ`, 4, number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT; used only with `ALU_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle, one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand A; requester i at slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`.
- `req_opcode`  in  NREQ*4  ALU opcode; requester i at slice [i*4 +: 4].
- `rsp_valid`  out  NREQ  one-cycle response strobe to the granted requester.
- `rsp_result`  out  WIDTH  result; shared by all requesters, qualified by `rsp_valid`.
- `rsp_flags`  out  4  flags {Z,N,C,V}, ALU encoding.
- `rsp_error`  out  1  response produced by timeout; qualified by `rsp_valid`.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_opcode`  out  4  registered opcode to the ALU.
- `alu_execute`  out  1  one-cycle start pulse.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flags`  in  4  ALU flags.
- `alu_done`  in  1  ALU completion.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, select winner g by round-robin. Search starts at `last_grant+1` and wraps modulo NREQ.
  - `req_ready[g]` is driven combinationally high for that cycle only.
  - On that edge, register g, `alu_a`/`alu_b`/`alu_opcode` from slice g, and `last_grant <= g`. Go to ISSUE.
  - With no `req_valid` high, stay in IDLE. `req_ready` is all zero.
- ISSUE: `alu_execute = 1` for exactly this cycle. Go to WAIT.
- WAIT:
  - Completion is the rising edge of `alu_done`, detected with a registered `done_q`: event = `alu_done & ~done_q`.
  - A `done` already high when WAIT is entered does not complete the operation.
  - On the event, capture `alu_result`/`alu_flags` into `rsp_result`/`rsp_flags`, clear `rsp_error`, and go to RESP.
- RESP: `rsp_valid[g] = 1` for one cycle. Go to IDLE.
- `rsp_result`/`rsp_flags`/`rsp_error` hold their values until the next capture.
- `alu_a`/`alu_b`/`alu_opcode` hold from acceptance until the next acceptance.
- Requester rules:
  - Once `req_valid[i]` is asserted, it stays high with stable operands until `req_ready[i]`.
  - A requester may present its next request while its response is still outstanding. That request is not accepted before RESP completes.
- Arbitration is fair: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0.
- Opcode values are passed through unchecked. Flag meaning is owned by the ALU.

## Timing
- Reset values:
  - FSM in IDLE, `last_grant = NREQ-1`, so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `alu_execute`, `rsp_error` = 0.
  - `rsp_result`, `rsp_flags`, `alu_a`, `alu_b`, `alu_opcode` = 0.
  - `done_q` = 0, and the timeout counter = 0.
- Reset mid-operation: everything returns to reset values asynchronously. No response is issued for the in-flight request. The ALU shares `rst_n`.
- Latency:
  - Acceptance edge → `alu_execute` high in the next cycle.
  - `alu_done` rising edge sampled → `rsp_valid` high in the next cycle.
- Throughput: one operation per 3 + L cycles, where L is the number of cycles spent in WAIT. Grant, issue and response add a fixed 3 cycles.
- Grant and `rsp_valid` never coincide. A new grant occurs at the earliest in the cycle after RESP.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If it reaches `TIMEOUT_CYCLES` without a done event, go to RESP.
  - The timeout response carries `rsp_error = 1`, `rsp_result = 0` and `rsp_flags = 0`.
  - The counter clears on entry to WAIT.
- Not defined:
  - No counter; WAIT lasts until a done event.
  - `rsp_error` is tied to 0, and the port list is unchanged.

## Structure
- Package `alu_arb_pkg`:
  - FSM state enum.
  - ALU opcode localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7, CMP=8, MUL=9.
  - Flag indices: ZERO=3, NEG=2, CARRY=1, OVF=0.
- Sub-module `rr_arbiter`:
  - Parameter NREQ.
  - Inputs: request vector, `last_grant`.
  - Outputs: one-hot grant, grant index, any-request flag.
  - Combinational.

## Test plan
- Single request, bench couples the arbiter to `simple_alu`: requester 0 sends ADD a=05 b=03 → `rsp_valid[0]` pulse, `rsp_result`=08, `rsp_flags`=0000, `rsp_error`=0.
- Contention: requesters 0–3 present ADD 01+00, 02+00, 03+00, 04+00 simultaneously → responses come in order 0,1,2,3 with results 01..04. A second round also starts at requester 0.
- Fairness: requester 1 requests continuously, requester 2 requests once → requester 2 is granted directly after requester 1's first response.
- Stuck done: hold `alu_done` high from before ISSUE with no new rising edge → no response is issued until `done` falls and rises again.
- Timeout, with `ALU_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, ALU `done` never asserted → `rsp_valid` pulses, `rsp_error`=1, `rsp_result`=00. The next request (SUB 08−03) completes normally with result 05.
- Reset mid-operation: assert `rst_n`=0 during WAIT → all outputs go to reset values immediately and no `rsp_valid` is issued. After release, MUL 04*05 from requester 2 returns result 14.
